// File: rtl/mesh_led_scheduler_pkg.sv
// Shared constants, display state type and ID helper for the sensor-mesh LED scheduler.
package mesh_pkg;
    localparam int NODES = 16;
    localparam int ID_W  = 4;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } disp_state_t;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return id + 4'd1;
    endfunction
endpackage

// File: rtl/mesh_led_scheduler_if.sv
// Alert inputs, display outputs and queue status of the mesh LED scheduler.
interface mesh_led_scheduler_if;
    import mesh_pkg::*;

    logic [NODES-1:0] node_alert;
    logic             enable;
    logic [ID_W-1:0]  led;
    logic             led_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             dropped;

    modport master (
        output node_alert, enable,
        input  led, led_valid, fifo_count, fifo_full, dropped
    );

    modport slave (
        input  node_alert, enable,
        output led, led_valid, fifo_count, fifo_full, dropped
    );
endinterface

// File: rtl/mesh_led_scheduler_arbiter.sv
// Combinational round-robin pick of the first pending node at or above rr_ptr.
module mesh_rr_arbiter
    import mesh_pkg::*;
(
    input  logic [NODES-1:0] pending,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id
);
    logic [ID_W-1:0] idx_s;
    logic            hit_s;

    // Upward scan; the 4-bit index wraps 15->0 on its own.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = {ID_W{1'b0}};
        idx_s     = {ID_W{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            idx_s     = rr_ptr + ID_W'(i);
            hit_s     = pending[idx_s] & ~gnt_valid;
            gnt_id    = hit_s ? idx_s : gnt_id;
            gnt_valid = gnt_valid | hit_s;
        end
    end
endmodule

// File: rtl/mesh_led_scheduler.sv
// Captures node alert rises, queues node IDs round-robin and paces them onto the LEDs.
module mesh_led_scheduler
    import mesh_pkg::*;
#(
    parameter int HOLD_CYC = 25_000_000,
    parameter int GAP_CYC  = 2_500_000
) (
    input  logic                 clk,
    input  logic                 reset,
    mesh_led_scheduler_if.slave  bus
);
    localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int HC_W    = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYC - 1);
    localparam logic [HC_W-1:0]  GAP_LOAD  = HC_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [NODES-1:0] alert_q_r, pending_r, rise_s, gnt_mask_s;
    logic [ID_W-1:0]  rr_ptr_r, arb_id_s, led_r, led_nxt_s;
    logic             arb_valid_s, push_s, pop_s;
    logic [ID_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             fifo_full_r, dropped_r, led_valid_r, led_valid_nxt_s;
    disp_state_t      state_r, state_nxt_s;
    logic [HC_W-1:0]  hold_cnt_r, hold_nxt_s;

    mesh_rr_arbiter u_arb (
        .pending   (pending_r),
        .rr_ptr    (rr_ptr_r),
        .gnt_valid (arb_valid_s),
        .gnt_id    (arb_id_s)
    );

    // Grant uses the registered count, so a same-cycle pop never frees room for a push.
    assign rise_s     = bus.node_alert & ~alert_q_r;
    assign push_s     = arb_valid_s & (count_r < FULL_CNT);
    assign gnt_mask_s = push_s ? ({{(NODES-1){1'b0}}, 1'b1} << arb_id_s) : {NODES{1'b0}};

    // Queue occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Display pacing: SHOW for HOLD_CYC cycles, then GAP_CYC+1 blank cycles before a new pop.
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_cnt_r;
        led_nxt_s       = led_r;
        led_valid_nxt_s = led_valid_r;
        pop_s           = 1'b0;
        case (state_r)
            IDLE: begin
                led_nxt_s       = {ID_W{1'b0}};
                led_valid_nxt_s = 1'b0;
                if (bus.enable && (count_r != {CNT_W{1'b0}})) begin
                    pop_s           = 1'b1;
                    led_nxt_s       = mem_r[rd_ptr_r];
                    led_valid_nxt_s = 1'b1;
                    hold_nxt_s      = HOLD_LOAD;
                    state_nxt_s     = SHOW;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            SHOW: begin
                if (hold_cnt_r == {HC_W{1'b0}}) begin
                    led_nxt_s       = {ID_W{1'b0}};
                    led_valid_nxt_s = 1'b0;
                    hold_nxt_s      = GAP_LOAD;
                    state_nxt_s     = GAP;
                end else begin
                    hold_nxt_s      = hold_cnt_r - HC_W'(1);
                end
            end
            GAP: begin
                if (hold_cnt_r == {HC_W{1'b0}}) begin
                    state_nxt_s     = IDLE;
                end else begin
                    hold_nxt_s      = hold_cnt_r - HC_W'(1);
                end
            end
            default: begin
                led_nxt_s       = {ID_W{1'b0}};
                led_valid_nxt_s = 1'b0;
                hold_nxt_s      = {HC_W{1'b0}};
                state_nxt_s     = IDLE;
            end
        endcase
    end

    // Edge capture, pending set/clear (set wins), arbiter pointer and merge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alert_q_r <= {NODES{1'b0}};
            pending_r <= {NODES{1'b0}};
            rr_ptr_r  <= {ID_W{1'b0}};
            dropped_r <= 1'b0;
        end else begin
            alert_q_r <= bus.node_alert;
            pending_r <= (pending_r & ~gnt_mask_s) | rise_s;
            dropped_r <= |(rise_s & pending_r & ~gnt_mask_s);
            if (push_s) begin
                rr_ptr_r <= next_id(arb_id_s);
            end
        end
    end

    // Node-ID queue storage, pointers and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ID_W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            fifo_full_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= arb_id_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            fifo_full_r <= (count_nxt_s == FULL_CNT);
        end
    end

    // Display state and registered LED outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_cnt_r  <= {HC_W{1'b0}};
            led_r       <= {ID_W{1'b0}};
            led_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            led_r       <= led_nxt_s;
            led_valid_r <= led_valid_nxt_s;
        end
    end

    assign bus.led        = led_r;
    assign bus.led_valid  = led_valid_r;
    assign bus.fifo_count = count_r;
    assign bus.fifo_full  = fifo_full_r;
    assign bus.dropped    = dropped_r;
endmodule

// File: tb/tb_mesh_led_scheduler.sv
// Directed bench for mesh_led_scheduler with a per-cycle event-level reference model.
module tb_mesh_led_scheduler;
    import mesh_pkg::*;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic reset;
    mesh_led_scheduler_if bus();

    mesh_led_scheduler #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sets of pending nodes, a list of queued IDs, remaining show/blank cycles.
    bit [15:0] m_alert_q, m_pend;
    int        m_rr, m_show, m_blank, m_led;
    bit        m_drop;
    int        m_q[$];

    int seen[$];
    int drop_pulses = 0;
    bit prev_valid  = 1'b0;

    function automatic void m_reset();
        m_alert_q = 16'h0000;
        m_pend    = 16'h0000;
        m_rr      = 0;
        m_show    = 0;
        m_blank   = 0;
        m_led     = 0;
        m_drop    = 1'b0;
        m_q.delete();
    endfunction

    function automatic void m_step(input bit [15:0] alert, input bit en);
        bit [15:0] rise = alert & ~m_alert_q;
        bit [15:0] gm   = 16'h0000;
        int        g    = -1;
        int        pre  = m_q.size();
        if (m_pend != 16'h0000 && pre < 8)
            for (int o = 0; o < 16; o++)
                if (g < 0 && m_pend[(m_rr + o) % 16]) g = (m_rr + o) % 16;
        if (g >= 0) gm[g] = 1'b1;
        m_drop    = |(rise & m_pend & ~gm);
        m_pend    = (m_pend & ~gm) | rise;
        m_alert_q = alert;
        if (m_show == 0 && m_blank == 0) begin
            if (en && pre > 0) begin
                m_led  = m_q.pop_front();
                m_show = HOLD;
            end
        end else if (m_show > 0) begin
            m_show--;
            if (m_show == 0) m_blank = GAP;
        end else begin
            m_blank--;
        end
        if (g >= 0) begin
            m_q.push_back(g);
            m_rr = (g + 1) % 16;
        end
    endfunction

    // Compare process: advance the model on each rising edge and check all outputs just after.
    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (reset) m_reset();
            else m_step(bus.node_alert, bus.enable);
            #1;
            chk("led_valid",  int'(bus.led_valid),  int'(m_show > 0));
            chk("led",        int'(bus.led),        (m_show > 0) ? m_led : 0);
            chk("fifo_count", int'(bus.fifo_count), m_q.size());
            chk("fifo_full",  int'(bus.fifo_full),  int'(m_q.size() == 8));
            chk("dropped",    int'(bus.dropped),    int'(m_drop));
            if (bus.led_valid && !prev_valid) seen.push_back(int'(bus.led));
            if (bus.dropped) drop_pulses++;
            prev_valid = bus.led_valid;
        end
    end

    task automatic chk_seq(input string name, input int start, input int exp[$]);
        chk({name, "_count"}, seen.size() - start, exp.size());
        for (int i = 0; i < exp.size() && (start + i) < seen.size(); i++)
            chk(name, seen[start + i], exp[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int mark;
    int dmark;
    bit got;

    // Directed stimulus, driven on falling edges.
    initial begin
        reset          = 1'b1;
        bus.node_alert = 16'h0000;
        bus.enable     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_led",   int'(bus.led),        0);
        chk("rst_valid", int'(bus.led_valid),  0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_drop",  int'(bus.dropped),    0);

        // Idle after reset
        repeat (20) @(negedge clk);
        chk("idle_count", int'(bus.fifo_count), 0);
        chk("idle_valid", int'(bus.led_valid),  0);

        // Single alert: shown from k+2 for 4 cycles, then 3 blank cycles
        bus.node_alert[5] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t2_k1_valid", int'(bus.led_valid), 0);
        @(posedge clk); #1;
        chk("t2_k2_led",   int'(bus.led),       5);
        chk("t2_k2_valid", int'(bus.led_valid), 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t2_hold_valid", int'(bus.led_valid), 1);
        end
        repeat (3) begin
            @(posedge clk); #1;
            chk("t2_gap_valid", int'(bus.led_valid), 0);
            chk("t2_gap_led",   int'(bus.led),       0);
        end
        @(negedge clk);
        bus.node_alert = 16'h0000;
        repeat (5) @(negedge clk);

        // Three simultaneous rises from rr_ptr=0
        do_reset();
        mark  = seen.size();
        dmark = drop_pulses;
        bus.node_alert = 16'h1208;
        repeat (40) @(negedge clk);
        chk_seq("t3_order", mark, '{3, 9, 12});
        chk("t3_drops", drop_pulses - dmark, 0);
        bus.node_alert = 16'h0000;
        repeat (5) @(negedge clk);

        // Grant 9 (rr_ptr -> 10), then 2 and 10 together: 10 first
        mark = seen.size();
        bus.node_alert[9] = 1'b1;
        repeat (3) @(negedge clk);
        bus.node_alert[2]  = 1'b1;
        bus.node_alert[10] = 1'b1;
        repeat (40) @(negedge clk);
        chk_seq("t4_order", mark, '{9, 10, 2});
        bus.node_alert = 16'h0000;
        repeat (5) @(negedge clk);

        // Ten rises with display blocked: queue fills, 8 and 9 stay pending
        do_reset();
        mark = seen.size();
        bus.enable     = 1'b0;
        bus.node_alert = 16'h03FF;
        repeat (9) @(negedge clk);
        chk("t5_count", int'(bus.fifo_count), 8);
        chk("t5_full",  int'(bus.fifo_full),  1);
        chk("t5_valid", int'(bus.led_valid),  0);
        bus.enable = 1'b1;
        repeat (90) @(negedge clk);
        chk_seq("t5_order", mark, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        chk("t5_drained", int'(bus.fifo_count), 0);
        bus.node_alert = 16'h0000;
        repeat (5) @(negedge clk);

        // Re-rise of node 7 while it is held pending behind a full queue
        do_reset();
        dmark = drop_pulses;
        bus.enable     = 1'b0;
        bus.node_alert = 16'hFF00;
        repeat (10) @(negedge clk);
        chk("t6_full", int'(bus.fifo_full), 1);
        bus.node_alert[7] = 1'b1;
        @(negedge clk);
        bus.node_alert[7] = 1'b0;
        @(negedge clk);
        bus.node_alert[7] = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_drop_pulses", drop_pulses - dmark, 1);

        // Reset in the middle of SHOW clears outputs before the next edge
        bus.enable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus.led_valid;
        end
        chk("t6_show_reached", int'(got), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_led",   int'(bus.led),        0);
        chk("t6_async_valid", int'(bus.led_valid),  0);
        chk("t6_async_count", int'(bus.fifo_count), 0);
        @(negedge clk);
        reset          = 1'b0;
        bus.node_alert = 16'h0000;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
